unified_mem_arbiter: RTL

- Shares one single-ported 64-bit unified memory between the core's instruction-fetch port and its data load/store port.
- Arbitrates one access at a time and sequences the memory's fixed read latency.
- Returns responses to the owning requester.
- Sits between the core datapath and the memory inside top. It replaces the separate instruction and data memories.

---
 rtl/unified_mem_arbiter_pkg.sv | 23 ++
 rtl/unified_mem_arbiter_if.sv | 32 +++
 rtl/unified_mem_arbiter_arb_priority.sv | 32 +++
 rtl/unified_mem_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified I/D memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  typedef enum logic [1:0] {
    MW_READ  = 2'b00,
    MW_WORD  = 2'b01,
    MW_DWORD = 2'b10
  } mem_we_t;

  typedef enum logic {OWN_I, OWN_D} owner_t;

  // Encoding 11 has no meaning at the memory, so it is folded onto a dword store.
  function automatic mem_we_t map_we(input logic [1:0] we);
    case (we)
      2'b00:   map_we = MW_READ;
      2'b01:   map_we = MW_WORD;
      default: map_we = MW_DWORD;
    endcase
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; slave = arbiter side.
interface unified_mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [1:0]  d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_ready;
  logic        d_valid;
  logic [63:0] d_rdata;
  logic        m_en;
  logic [1:0]  m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_ready, i_valid, i_rdata, d_ready, d_valid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_ready, i_valid, i_rdata, d_ready, d_valid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter_arb_priority.sv
// Data-first tie-break with a saturating starve counter that forces a fetch grant.
module arb_priority
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   grant,
  output owner_t winner
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    winner = (i_req && (!d_req || starve_q == SMAX)) ? OWN_I : OWN_D;
    starve_d = starve_q;
    if (grant) begin
      if (winner == OWN_I)               starve_d = '0;
      else if (i_req && starve_q != SMAX) starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end
endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-outstanding arbiter between fetch and load/store ports onto one memory.
// Optional grant/stall counters are built when ARB_STATS_EN is defined.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  unified_mem_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]            stat_igrant,
  output logic [31:0]            stat_dgrant,
  output logic [31:0]            stat_stall
`endif
);
  arb_state_t  state_q, state_d;
  owner_t      owner_q, owner_d, winner;
  logic        lane_q, lane_d, store_q, store_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        m_en_q, m_en_d;
  logic [1:0]  m_we_q, m_we_d;
  logic [63:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic        i_ready_q, i_ready_d, d_ready_q, d_ready_d;
  logic        i_valid_q, i_valid_d, d_valid_q, d_valid_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [63:0] d_rdata_q, d_rdata_d;
  logic        grant;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.i_addr[1:0];
  assign grant = (state_q == IDLE) && (bus.i_req || bus.d_req);

  arb_priority #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk    (clk),
    .reset  (reset),
    .i_req  (bus.i_req),
    .d_req  (bus.d_req),
    .grant  (grant),
    .winner (winner)
  );

  // Strobe-type outputs default to 0 each cycle so they only ever pulse.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lane_d    = lane_q;
    store_d   = store_q;
    cnt_d     = cnt_q;
    m_en_d    = 1'b0;
    m_we_d    = MW_READ;
    m_addr_d  = '0;
    m_wdata_d = '0;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    i_rdata_d = '0;
    d_rdata_d = '0;
    case (state_q)
      IDLE: if (grant) begin
        state_d = ISSUE;
        owner_d = winner;
        m_en_d  = 1'b1;
        if (winner == OWN_I) begin
          m_addr_d  = {32'h0, bus.i_addr[31:3], 3'b000};
          lane_d    = bus.i_addr[2];
          store_d   = 1'b0;
          i_ready_d = 1'b1;
        end else begin
          m_we_d    = map_we(bus.d_we);
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          store_d   = (bus.d_we != 2'b00);
          d_ready_d = 1'b1;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (store_q) begin
          state_d   = RESP;
          d_valid_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Capture lands on the edge MEM_LAT cycles after the m_en cycle.
        if (cnt_q == 3'(MEM_LAT - 1)) begin
          state_d = RESP;
          if (owner_q == OWN_I) begin
            i_valid_d = 1'b1;
            i_rdata_d = lane_q ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = bus.m_rdata;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      lane_q    <= 1'b0;
      store_q   <= 1'b0;
      cnt_q     <= '0;
      m_en_q    <= 1'b0;
      m_we_q    <= MW_READ;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lane_q    <= lane_d;
      store_q   <= store_d;
      cnt_q     <= cnt_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.m_en    = m_en_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_ready = i_ready_q;
  assign bus.d_ready = d_ready_q;
  assign bus.i_valid = i_valid_q;
  assign bus.d_valid = d_valid_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

`ifdef ARB_STATS_EN
  logic [31:0] sig_q, sig_d, sdg_q, sdg_d, sst_q, sst_d;
  logic        igrant;

  assign igrant = grant && (winner == OWN_I);

  always_comb begin
    sig_d = sig_q + {31'h0, igrant};
    sdg_d = sdg_q + {31'h0, grant && (winner == OWN_D)};
    sst_d = sst_q + {31'h0, bus.i_req && !igrant};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_q <= '0;
      sdg_q <= '0;
      sst_q <= '0;
    end else begin
      sig_q <= sig_d;
      sdg_q <= sdg_d;
      sst_q <= sst_d;
    end
  end

  assign stat_igrant = sig_q;
  assign stat_dgrant = sdg_q;
  assign stat_stall  = sst_q;
`endif
endmodule
